// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, the operation enum and the controller state enum.
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      MULT  = OP_MULT,
      MULTU = OP_MULTU,
      DIV   = OP_DIV,
      DIVU  = OP_DIVU
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FIXUP = 2'b10,
      DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One radix-2 iteration of the shared datapath, purely combinational.
//   multiply : shift-add. {acc, sreg} shifts right; sreg[0] selects whether
//              the multiplicand is added first. Product ends up in
//              {acc[WIDTH-1:0], sreg}.
//   divide   : restoring shift-subtract. {acc, sreg} shifts left; the trial
//              subtraction is kept when it does not borrow, and the quotient
//              bit enters sreg[0]. Remainder ends up in acc, quotient in sreg.
// Ports:
//   i_is_div  1        select divide (1) or multiply (0) step
//   i_acc     WIDTH+1  accumulator in
//   i_sreg    WIDTH    shift register in (multiplier / dividend-quotient)
//   i_opnd    WIDTH    multiplicand / divisor magnitude
//   o_acc     WIDTH+1  accumulator out
//   o_sreg    WIDTH    shift register out
// -----------------------------------------------------------------------------
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_is_div,
   input  logic [WIDTH:0]   i_acc,
   input  logic [WIDTH-1:0] i_sreg,
   input  logic [WIDTH-1:0] i_opnd,
   output logic [WIDTH:0]   o_acc,
   output logic [WIDTH-1:0] o_sreg
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;

   always_comb begin
      w_sum   = i_acc + (i_sreg[0] ? {1'b0, i_opnd} : '0);
      w_shift = {i_acc[WIDTH-1:0], i_sreg[WIDTH-1]};
      // Partial remainder is always below the divisor, so the MSB of the
      // (WIDTH+1)-bit difference is a clean borrow indicator.
      w_trial = w_shift - {1'b0, i_opnd};
      if (i_is_div) begin
         if (!w_trial[WIDTH]) begin
            o_acc  = w_trial;
            o_sreg = {i_sreg[WIDTH-2:0], 1'b1};
         end else begin
            o_acc  = w_shift;
            o_sreg = {i_sreg[WIDTH-2:0], 1'b0};
         end
      end else begin
         o_acc  = {1'b0, w_sum[WIDTH:1]};
         o_sreg = {w_sum[0], i_sreg[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Operands are reduced to magnitudes on start, WIDTH radix-2 steps run in
// CALC, FIXUP restores signs, and the result is visible during DONE.
// Ports:
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   i_start, i_op, i_a, i_b launch (sampled in IDLE only)
//   i_cancel                abort an operation in CALC/FIXUP
//   i_wr_hi, i_wr_lo, i_wdata  direct HI/LO load (IDLE only)
//   o_busy, o_done          status; o_done pulses with a new result
//   o_hi, o_lo              result registers
//   o_div_zero, o_ovf       divide-by-zero / signed-divide overflow flags
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cancel,
   input  logic             i_wr_hi,
   input  logic             i_wr_lo,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_div_zero,
   output logic             o_ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic             r_is_div, r_neg_q, r_neg_r, r_dz_pend, r_ov_pend;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_sreg, r_opnd, r_a;
   logic [WIDTH-1:0] r_hi, r_lo;
   logic             r_div_zero, r_ovf;

   logic             w_accept, w_signed, w_is_div;
   op_t              w_op;
   logic [WIDTH-1:0] w_a_mag, w_b_mag;
   logic [WIDTH:0]   w_step_acc;
   logic [WIDTH-1:0] w_step_sreg;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_fix_hi, w_fix_lo;

   function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] m;
      m = v[WIDTH-1] ? -v : v;
      return m;
   endfunction

   assign w_op     = op_t'(i_op);
   assign w_signed = (w_op == MULT) || (w_op == DIV);
   assign w_is_div = (w_op == DIV) || (w_op == DIVU);
   assign w_accept = (r_state == IDLE) && i_start && !i_cancel;
   assign w_a_mag  = w_signed ? f_abs(i_a) : i_a;
   assign w_b_mag  = w_signed ? f_abs(i_b) : i_b;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_sreg   (r_sreg),
      .i_opnd   (r_opnd),
      .o_acc    (w_step_acc),
      .o_sreg   (w_step_sreg)
   );

   // FSM: state register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= IDLE;
      else            r_state <= w_next;
   end

   // FSM: next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = CALC;
         CALC:    if (i_cancel) w_next = IDLE;
                  else if (r_cnt == CW'(1)) w_next = FIXUP;
         FIXUP:   w_next = i_cancel ? IDLE : DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_busy = (r_state != IDLE);
      o_done = (r_state == DONE);
   end

   // Sign correction of the raw magnitude results; special divide cases
   // override the arithmetic outcome.
   always_comb begin
      w_prod = {r_acc[WIDTH-1:0], r_sreg};
      if (r_neg_q) w_prod = -w_prod;
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
      if (r_is_div) begin
         w_fix_lo = r_neg_q ? -r_sreg : r_sreg;
         w_fix_hi = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
         if (r_dz_pend) begin
            w_fix_hi = r_a;
            w_fix_lo = '1;
         end else if (r_ov_pend) begin
            w_fix_hi = '0;
            w_fix_lo = r_a;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt      <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz_pend  <= 1'b0;
         r_ov_pend  <= 1'b0;
         r_acc      <= '0;
         r_sreg     <= '0;
         r_opnd     <= '0;
         r_a        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_div_zero <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_is_div   <= w_is_div;
            r_neg_q    <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r    <= w_signed && i_a[WIDTH-1];
            r_acc      <= '0;
            r_sreg     <= w_is_div ? w_a_mag : w_b_mag;
            r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
            r_a        <= i_a;
            r_cnt      <= CW'(WIDTH);
            r_dz_pend  <= w_is_div && (i_b == '0);
            r_ov_pend  <= (w_op == DIV) && (i_a == MOST_NEG) && (i_b == '1);
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
         end else if (r_state == CALC) begin
            r_acc  <= w_step_acc;
            r_sreg <= w_step_sreg;
            r_cnt  <= r_cnt - CW'(1);
         end
         if (r_state == IDLE) begin
            if (i_wr_hi) r_hi <= i_wdata;
            if (i_wr_lo) r_lo <= i_wdata;
         end else if (r_state == FIXUP && !i_cancel) begin
            // Registered on the FIXUP->DONE edge so results are visible
            // for the whole DONE cycle, alongside the done pulse.
            r_hi       <= w_fix_hi;
            r_lo       <= w_fix_lo;
            r_div_zero <= r_dz_pend;
            r_ovf      <= r_ov_pend;
         end
      end
   end

   assign o_hi       = r_hi;
   assign o_lo       = r_lo;
   assign o_div_zero = r_div_zero;
   assign o_ovf      = r_ovf;

endmodule
